counter_sweep_ctrl: RTL and testbench

Sequencing controller that drives the team's 5-bit up/down counter through its control interface (IN, Load, Up, Down) and consumes its status flags (High, Low). On a start request it loads a start value, ramps up to full scale, dwells, ramps down to zero, dwells, and repeats for a programmed number of sweeps. It then reports completion through a Start/Busy/Done handshake. It sits between a register/host interface and the counter instance, replacing hand-driven stimulus.

---
 rtl/counter_pkg.sv | 17 +
 rtl/sweep_dwell_timer.sv | 44 ++++
 rtl/counter_sweep_ctrl.sv | 162 ++++++++++++++++
 tb/tb_counter_sweep_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared types and constants for the counter sweep controller
package counter_pkg;

  localparam int COUNTER_WIDTH = 5;
  localparam int COUNTER_MAX   = 31;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_UP,
    ST_DWELL_HI,
    ST_DOWN,
    ST_DWELL_LO,
    ST_FINISH
  } sweep_state_e;

endpackage

// File: rtl/sweep_dwell_timer.sv
// rtl/sweep_dwell_timer.sv - dwell down-counter; a zero length dwells one cycle
module sweep_dwell_timer #(
  parameter int DW = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          load_i,
  input  logic [DW-1:0] len_i,
  output logic          expire_o
);

  localparam logic [DW-1:0] ONE = {{(DW-1){1'b0}}, 1'b1};

  logic [DW-1:0] cnt_q, cnt_d;
  logic          active_q, active_d;

  always_comb begin
    cnt_d    = cnt_q;
    active_d = active_q;
    if (load_i) begin
      active_d = 1'b1;
      cnt_d    = (len_i == '0) ? '0 : len_i - ONE;
    end else if (active_q) begin
      if (cnt_q == '0) begin
        active_d = 1'b0;
      end else begin
        cnt_d = cnt_q - ONE;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

  assign expire_o = active_q && (cnt_q == '0);

endmodule

// File: rtl/counter_sweep_ctrl.sv
// rtl/counter_sweep_ctrl.sv - up/down sweep sequencer for the 5-bit counter
// Optional shadow-counter checker built when COUNTER_SWEEP_CHECK_EN is defined.
module counter_sweep_ctrl
  import counter_pkg::*;
#(
  parameter int WIDTH = COUNTER_WIDTH,
  parameter int DW    = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Start,
  input  logic             Abort,
  input  logic [WIDTH-1:0] Start_Val,
  input  logic [DW-1:0]    Dwell,
  input  logic [DW-1:0]    Sweeps,
  input  logic             High,
  input  logic             Low,
  input  logic [WIDTH-1:0] Count,
  output logic [WIDTH-1:0] IN,
  output logic             Load,
  output logic             Up,
  output logic             Down,
  output logic             Busy,
  output logic             Done,
  output logic [DW-1:0]    Sweep_Cnt,
  output logic             Err
);

  localparam logic [DW-1:0] SWEEP_ONE = {{(DW-1){1'b0}}, 1'b1};

  sweep_state_e     state_q, state_d;
  logic [WIDTH-1:0] start_val_q, start_val_d;
  logic [DW-1:0]    dwell_q, dwell_d;
  logic [DW-1:0]    sweeps_q, sweeps_d;
  logic [DW-1:0]    sweep_cnt_q, sweep_cnt_d;
  logic             timer_load;
  logic             timer_expire;
  logic             start_ok;

  assign start_ok   = (state_q == ST_IDLE) && Start && !Abort;
  // One timer serves both dwells: it is armed on the cycle an extreme is reached.
  assign timer_load = !Abort && (((state_q == ST_UP) && High) || ((state_q == ST_DOWN) && Low));

  sweep_dwell_timer #(.DW(DW)) u_dwell_timer (
    .clk_i    (CLK),
    .rst_i    (RST),
    .load_i   (timer_load),
    .len_i    (dwell_q),
    .expire_o (timer_expire)
  );

  always_comb begin
    state_d     = state_q;
    start_val_d = start_val_q;
    dwell_d     = dwell_q;
    sweeps_d    = sweeps_q;
    sweep_cnt_d = sweep_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          start_val_d = Start_Val;
          dwell_d     = Dwell;
          sweeps_d    = Sweeps;
          sweep_cnt_d = '0;
          state_d     = ST_LOAD;
        end
      end
      ST_LOAD:     state_d = ST_UP;
      ST_UP:       if (High) state_d = ST_DWELL_HI;
      ST_DWELL_HI: if (timer_expire) state_d = ST_DOWN;
      ST_DOWN:     if (Low) state_d = ST_DWELL_LO;
      ST_DWELL_LO: begin
        if (timer_expire) begin
          sweep_cnt_d = sweep_cnt_q + SWEEP_ONE;
          if ((sweeps_q != '0) && (sweep_cnt_d == sweeps_q)) begin
            state_d = ST_FINISH;
          end else begin
            state_d = ST_UP;
          end
        end
      end
      ST_FINISH:   state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
    if ((state_q != ST_IDLE) && Abort) begin
      state_d     = ST_IDLE;
      sweep_cnt_d = sweep_cnt_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      start_val_q <= '0;
      dwell_q     <= '0;
      sweeps_q    <= '0;
      sweep_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      start_val_q <= start_val_d;
      dwell_q     <= dwell_d;
      sweeps_q    <= sweeps_d;
      sweep_cnt_q <= sweep_cnt_d;
    end
  end

  assign IN        = start_val_q;
  assign Load      = (state_q == ST_LOAD);
  assign Up        = (state_q == ST_UP);
  assign Down      = (state_q == ST_DOWN);
  assign Busy      = (state_q != ST_IDLE);
  assign Done      = (state_q == ST_FINISH);
  assign Sweep_Cnt = sweep_cnt_q;

`ifdef COUNTER_SWEEP_CHECK_EN
  localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] model_q, model_d;
  logic             model_vld_q, model_vld_d;
  logic             err_q, err_d;

  // Model mirrors the counter's priority: Load, then Down, then Up, saturating.
  always_comb begin
    model_d     = model_q;
    err_d       = err_q;
    model_vld_d = Load || (model_vld_q && Busy);
    if (Load) begin
      model_d = start_val_q;
    end else if (Down && (model_q != '0)) begin
      model_d = model_q - CNT_ONE;
    end else if (Up && (model_q != CNT_MAX)) begin
      model_d = model_q + CNT_ONE;
    end
    if (Busy && model_vld_q && (Count != model_q)) begin
      err_d = 1'b1;
    end
    if (start_ok) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      model_q     <= '0;
      model_vld_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      model_q     <= model_d;
      model_vld_q <= model_vld_d;
      err_q       <= err_d;
    end
  end

  assign Err = err_q;
`else
  logic unused_count;
  assign unused_count = ^Count;
  assign Err          = 1'b0;
`endif

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// tb/tb_counter_sweep_ctrl.sv - directed self-checking bench with a behavioural 5-bit counter
module tb_counter_sweep_ctrl;

  logic       CLK = 1'b0;
  logic       RST, Start, Abort;
  logic [4:0] Start_Val;
  logic [3:0] Dwell, Sweeps;
  logic [4:0] IN, cnt, count_in;
  logic       Load, Up, Down, Busy, Done, Err, frc;
  logic [3:0] Sweep_Cnt;
  logic       High, Low;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef COUNTER_SWEEP_CHECK_EN
  localparam int ERR_EXP = 1;
`else
  localparam int ERR_EXP = 0;
`endif

  always #5 CLK = ~CLK;

  // Reference counter: Load first, then Down, then Up, saturating at both ends.
  always @(posedge CLK) begin
    if (RST)                        cnt <= 5'd0;
    else if (Load)                  cnt <= IN;
    else if (Down && cnt != 5'd0)   cnt <= cnt - 5'd1;
    else if (Up && cnt != 5'd31)    cnt <= cnt + 5'd1;
  end
  assign High     = (cnt == 5'd31);
  assign Low      = (cnt == 5'd0);
  assign count_in = frc ? 5'd7 : cnt;

  counter_sweep_ctrl dut (
    .CLK(CLK), .RST(RST), .Start(Start), .Abort(Abort),
    .Start_Val(Start_Val), .Dwell(Dwell), .Sweeps(Sweeps),
    .High(High), .Low(Low), .Count(count_in),
    .IN(IN), .Load(Load), .Up(Up), .Down(Down),
    .Busy(Busy), .Done(Done), .Sweep_Cnt(Sweep_Cnt), .Err(Err)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Starts a sweep and classifies each cycle until Done (cycle 1 = LOAD).
  task automatic run_sweep(input logic [4:0] sv, input logic [3:0] dw, input logic [3:0] sw,
                           input int budget, input int poke_at,
                           output int up_c, output int hi_c, output int dn_c, output int lo_c,
                           output int done_at, output int bad, output int load_c, output int steps);
    logic [3:0] prev;
    up_c = 0; hi_c = 0; dn_c = 0; lo_c = 0; done_at = 0; bad = 0; load_c = 0; steps = 0;
    prev = 4'd0;
    Start_Val = sv; Dwell = dw; Sweeps = sw; Start = 1'b1;
    tick();
    Start = 1'b0;
    for (int c = 1; c <= budget; c++) begin
      if ((Up && Down) || (Load && (Up || Down))) bad++;
      if (Load) load_c++;
      if (Sweep_Cnt != prev) begin
        if (Sweep_Cnt == prev + 4'd1) steps++;
        prev = Sweep_Cnt;
      end
      if (Up) up_c++;
      else if (Down) dn_c++;
      else if (Busy && !Load && !Done) begin
        if (cnt == 5'd31) hi_c++;
        else lo_c++;
      end
      if (Done) begin
        done_at = c;
        break;
      end
      Start = (c == poke_at);
      if (c == poke_at) Start_Val = 5'd3;
      tick();
      Start = 1'b0;
    end
  endtask

  int up_c, hi_c, dn_c, lo_c, done_at, bad, load_c, steps;
  int found, done_seen, wrapped;
  logic [3:0] prev_sc;

  initial begin
    RST = 1'b1; Start = 1'b0; Abort = 1'b0; frc = 1'b0;
    Start_Val = 5'd0; Dwell = 4'd0; Sweeps = 4'd0;
    tick(); tick();
    check_eq("rst_busy", Busy, 0);
    check_eq("rst_done", Done, 0);
    check_eq("rst_ctl", {Load, Up, Down}, 0);
    check_eq("rst_in", IN, 0);
    check_eq("rst_sweep_cnt", Sweep_Cnt, 0);
    check_eq("rst_err", Err, 0);
    RST = 1'b0;
    tick();

    // Normal single sweep from 5 with two-cycle dwells
    Start_Val = 5'd5; Dwell = 4'd2; Sweeps = 4'd1; Start = 1'b1;
    tick();
    Start = 1'b0;
    check_eq("load_strobe", Load, 1);
    check_eq("load_busy", Busy, 1);
    check_eq("load_in", IN, 5);
    check_eq("load_sweep_cnt", Sweep_Cnt, 0);
    Abort = 1'b1; tick(); Abort = 1'b0; tick();
    run_sweep(5'd5, 4'd2, 4'd1, 200, 0, up_c, hi_c, dn_c, lo_c, done_at, bad, load_c, steps);
    check_eq("n_done_cycle", done_at, 65);
    check_eq("n_up", up_c, 27);
    check_eq("n_dwell_hi", hi_c, 2);
    check_eq("n_down", dn_c, 32);
    check_eq("n_dwell_lo", lo_c, 2);
    check_eq("n_overlap", bad, 0);
    check_eq("n_sweep_cnt", Sweep_Cnt, 1);
    check_eq("n_err", Err, 0);
    tick();
    check_eq("n_busy_after", Busy, 0);
    check_eq("n_done_pulse", Done, 0);

    // Three sweeps with zero dwell
    run_sweep(5'd5, 4'd0, 4'd3, 400, 0, up_c, hi_c, dn_c, lo_c, done_at, bad, load_c, steps);
    check_eq("m_done_cycle", done_at, 195);
    check_eq("m_up", up_c, 91);
    check_eq("m_dwell_hi", hi_c, 3);
    check_eq("m_down", dn_c, 96);
    check_eq("m_dwell_lo", lo_c, 3);
    check_eq("m_steps", steps, 3);
    check_eq("m_sweep_cnt", Sweep_Cnt, 3);
    tick();

    // Start_Val at full scale, with a Start poked mid-sweep
    run_sweep(5'd31, 4'd1, 4'd1, 100, 5, up_c, hi_c, dn_c, lo_c, done_at, bad, load_c, steps);
    check_eq("b31_up", up_c, 1);
    check_eq("b31_done_cycle", done_at, 37);
    check_eq("busy_start_loads", load_c, 1);
    check_eq("busy_start_in", IN, 31);
    tick();

    // Start_Val zero gets a full ramp
    run_sweep(5'd0, 4'd3, 4'd1, 150, 0, up_c, hi_c, dn_c, lo_c, done_at, bad, load_c, steps);
    check_eq("b0_up", up_c, 32);
    check_eq("b0_dwell_hi", hi_c, 3);
    check_eq("b0_done_cycle", done_at, 72);
    tick();

    // Start and Abort together in IDLE
    Start_Val = 5'd9; Start = 1'b1; Abort = 1'b1;
    tick();
    Start = 1'b0; Abort = 1'b0;
    check_eq("sa_busy", Busy, 0);
    check_eq("sa_load", Load, 0);
    tick();
    check_eq("sa_busy2", Busy, 0);

    // Abort while ramping down at Count 12 in the second sweep
    Start_Val = 5'd20; Dwell = 4'd1; Sweeps = 4'd2; Start = 1'b1;
    tick();
    Start = 1'b0;
    found = 0;
    for (int c = 0; c < 300; c++) begin
      if (Sweep_Cnt == 4'd1 && Down && cnt == 5'd12) begin
        found = 1;
        break;
      end
      tick();
    end
    check_eq("ab_reached", found, 1);
    Abort = 1'b1;
    tick();
    Abort = 1'b0;
    check_eq("ab_busy", Busy, 0);
    check_eq("ab_ctl", {Load, Up, Down}, 0);
    check_eq("ab_done", Done, 0);
    check_eq("ab_sweep_cnt", Sweep_Cnt, 1);
    done_seen = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (Done) done_seen = 1;
    end
    check_eq("ab_no_done", done_seen, 0);

    // Continuous mode: Sweep_Cnt wraps 15 -> 0 with no Done
    Start_Val = 5'd0; Dwell = 4'd0; Sweeps = 4'd0; Start = 1'b1;
    tick();
    Start = 1'b0;
    done_seen = 0; wrapped = 0; prev_sc = 4'd0;
    for (int c = 0; c < 1500; c++) begin
      if (Done) done_seen = 1;
      if (prev_sc == 4'd15 && Sweep_Cnt == 4'd0) begin
        wrapped = 1;
        break;
      end
      prev_sc = Sweep_Cnt;
      tick();
    end
    check_eq("c_wrapped", wrapped, 1);
    check_eq("c_no_done", done_seen, 0);
    check_eq("c_busy", Busy, 1);
    Abort = 1'b1;
    tick();
    Abort = 1'b0;
    check_eq("c_abort_busy", Busy, 0);
    check_eq("c_abort_done", Done, 0);

    // Checker: present 7 when the counter holds 8
    Start_Val = 5'd5; Dwell = 4'd1; Sweeps = 4'd1; Start = 1'b1;
    tick();
    Start = 1'b0;
    found = 0;
    for (int c = 0; c < 50; c++) begin
      tick();
      if (Up && cnt == 5'd8) begin
        found = 1;
        break;
      end
    end
    check_eq("ck_reached", found, 1);
    frc = 1'b1;
    tick();
    frc = 1'b0;
    check_eq("ck_err_set", Err, ERR_EXP);
    tick(); tick(); tick();
    check_eq("ck_err_sticky", Err, ERR_EXP);
    Abort = 1'b1; tick(); Abort = 1'b0;
    check_eq("ck_err_idle", Err, ERR_EXP);
    Start = 1'b1;
    tick();
    Start = 1'b0;
    check_eq("ck_err_cleared", Err, 0);
    tick(); tick();
    check_eq("ck_err_stays_clear", Err, 0);

    // Reset mid-sweep overrides a concurrent Start
    RST = 1'b1; Start = 1'b1;
    tick();
    RST = 1'b0; Start = 1'b0;
    check_eq("r_busy", Busy, 0);
    check_eq("r_in", IN, 0);
    check_eq("r_ctl", {Load, Up, Down, Done}, 0);
    check_eq("r_sweep_cnt", Sweep_Cnt, 0);
    check_eq("r_err", Err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
